ime_stream_tx: RTL and testbench

// Egress stream interface at the tail of the IME pipeline; the transmit-side counterpart of the S0 ingress block.

---
 rtl/ime_stream_tx.sv | 174 +++++++++++++++++
 tb/tb_ime_stream_tx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ime_stream_tx.sv
// ime_stream_tx: egress AXI-Stream master at the tail of the IME pipeline.
// Buffers per-sample results in a small FIFO and streams them downstream. Poison is made
// frame-sticky and reported in tuser[7]. An optional constant-time floor holds back the last
// beat of a frame until a minimum number of cycles has elapsed since the frame started.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_valid/in_ready              upstream handshake (in_ready = FIFO not full)
//   in_data/in_tuser/in_last       sample, sideband (bit7 ignored), end-of-frame flag
//   in_poison                      sample poisoned
//   m_axis_t*                      AXI-Stream master, fields taken from the FIFO head
//   const_time_cycles, ct_enable   constant-time floor, latched at frame start
//   frame_sent/poison_seen         registered 1-cycle pulses after the last-beat handshake
//   ct_overrun                     registered pulse: frame took longer than the floor
//   fifo_level                     FIFO occupancy
module ime_stream_tx #(
    parameter int unsigned W_ACC      = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CT_W       = 14
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [W_ACC-1:0]              in_data,
    input  logic [7:0]                    in_tuser,
    input  logic                          in_last,
    input  logic                          in_poison,
    output logic [W_ACC-1:0]              m_axis_tdata,
    output logic [7:0]                    m_axis_tuser,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    input  logic [CT_W-1:0]               const_time_cycles,
    input  logic                          ct_enable,
    output logic                          frame_sent,
    output logic                          poison_seen,
    output logic                          ct_overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    // Entry layout: {data, tuser[6:0], last, poison}
    localparam int unsigned EW = W_ACC + 9;
    localparam logic [AW:0] FullLvl = FIFO_DEPTH[AW:0];
    localparam logic [CT_W-1:0] TimerMax = '1;

    typedef enum logic [1:0] {StIdle, StStream, StHold} state_e;

    logic [EW-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q;
    logic            sticky_q;
    state_e          state_q, state_d;
    logic [CT_W-1:0] timer_q, timer_d;
    logic [CT_W-1:0] ct_target_q, ct_target_d;
    logic            ct_en_lat_q, ct_en_lat_d;
    logic            frame_sent_q, poison_seen_q, ct_overrun_q;

    logic            full, empty, push, pop, last_hs, tvalid;
    logic [EW-1:0]   head;
    logic            head_last, head_poison;

    assign full        = (count_q == FullLvl);
    assign empty       = (count_q == '0);
    assign in_ready    = !full;
    assign push        = in_valid && !full;
    assign pop         = tvalid && m_axis_tready;
    assign head        = mem_q[rd_ptr_q];
    assign head_last   = head[1];
    assign head_poison = head[0];
    assign last_hs     = pop && head_last;

    assign m_axis_tdata  = head[EW-1 -: W_ACC];
    assign m_axis_tuser  = {head_poison, head[8:2]};
    assign m_axis_tlast  = head_last;
    assign m_axis_tvalid = tvalid;
    assign fifo_level    = count_q;
    assign frame_sent    = frame_sent_q;
    assign poison_seen   = poison_seen_q;
    assign ct_overrun    = ct_overrun_q;

    // Storage needs no reset: only entries below count_q are ever presented as valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_data, in_tuser[6:0], in_last, sticky_q | in_poison};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            sticky_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                // Sticky poison spans the frame and is cleared once its last sample is in.
                sticky_q <= in_last ? 1'b0 : (sticky_q | in_poison);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (!push && pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        ct_target_d = ct_target_q;
        ct_en_lat_d = ct_en_lat_q;
        tvalid      = 1'b0;
        if (state_q != StIdle && timer_q != TimerMax) begin
            timer_d = timer_q + 1'b1;
        end
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    state_d     = StStream;
                    timer_d     = '0;
                    ct_en_lat_d = ct_enable;
                    ct_target_d = ct_enable ? const_time_cycles : '0;
                end
            end
            StStream: begin
                if (!empty && head_last && (timer_q < ct_target_q)) begin
                    state_d = StHold;
                end else begin
                    tvalid = !empty;
                    if (tvalid && m_axis_tready && head_last) begin
                        state_d = StIdle;
                    end
                end
            end
            StHold: begin
                // Timer only grows, so once released the beat stays valid until taken.
                if (timer_q >= ct_target_q) begin
                    tvalid = !empty;
                    if (tvalid && m_axis_tready) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            timer_q       <= '0;
            ct_target_q   <= '0;
            ct_en_lat_q   <= 1'b0;
            frame_sent_q  <= 1'b0;
            poison_seen_q <= 1'b0;
            ct_overrun_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            ct_target_q   <= ct_target_d;
            ct_en_lat_q   <= ct_en_lat_d;
            frame_sent_q  <= last_hs;
            poison_seen_q <= last_hs && head_poison;
            ct_overrun_q  <= last_hs && ct_en_lat_q && (timer_q > ct_target_q);
        end
    end

endmodule

// File: tb/tb_ime_stream_tx.sv
module tb_ime_stream_tx;

    localparam int W   = 32;
    localparam int D   = 4;
    localparam int CTW = 14;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, in_last, in_poison;
    logic [W-1:0]  in_data;
    logic [7:0]    in_tuser;
    logic [W-1:0]  m_axis_tdata;
    logic [7:0]    m_axis_tuser;
    logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [CTW-1:0] const_time_cycles;
    logic          ct_enable;
    logic          frame_sent, poison_seen, ct_overrun;
    logic [2:0]    fifo_level;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ime_stream_tx #(.W_ACC(W), .FIFO_DEPTH(D), .CT_W(CTW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tuser(in_tuser),
        .in_last(in_last), .in_poison(in_poison),
        .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
        .const_time_cycles(const_time_cycles), .ct_enable(ct_enable),
        .frame_sent(frame_sent), .poison_seen(poison_seen), .ct_overrun(ct_overrun),
        .fifo_level(fifo_level)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; in_tuser = '0; in_last = 1'b0; in_poison = 1'b0;
        m_axis_tready = 1'b0; const_time_cycles = '0; ct_enable = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++;
            $display("FAIL reset_tvalid got=%b exp=0", m_axis_tvalid); end
        checks++; if (in_ready !== 1'b1) begin errors++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (fifo_level !== 3'd0) begin errors++;
            $display("FAIL reset_level got=%0d exp=0", fifo_level); end
        checks++; if ({frame_sent, poison_seen, ct_overrun} !== 3'b000) begin errors++;
            $display("FAIL reset_pulses got=%b exp=000", {frame_sent, poison_seen, ct_overrun}); end
    endtask

    // Frames preloaded one sample per cycle with tready=1. Frame starts streaming one cycle
    // after the first push (period 1); the last beat is released at period 1+max(n-1, floor).
    task automatic test_frames();
        int n, tgt, tgt_eff, rise, p, bi;
        bit en, any_pz, sticky, exp_v, exp_ovr;
        logic [W-1:0] d [5];
        logic [6:0]   u [5];
        bit           pz [5];
        bit           stk [5];
        logic [7:0]   exp_user;
        for (int it = 0; it < 24; it++) begin
            n = $urandom_range(1, 5); en = 1'($urandom_range(0, 1)); tgt = $urandom_range(0, 12);
            for (int i = 0; i < 5; i++) begin
                d[i] = $urandom; u[i] = 7'($urandom); pz[i] = ($urandom_range(0, 3) == 0);
            end
            if (it == 0) begin
                n = 3; en = 0; d[0] = 32'h11; d[1] = 32'h22; d[2] = 32'h33;
                for (int i = 0; i < 5; i++) pz[i] = 0;
            end else if (it == 1) begin
                n = 2; en = 1; tgt = 10;
                for (int i = 0; i < 5; i++) pz[i] = 0;
            end else if (it == 2 || it == 3) begin
                n = 4; en = 0;
                for (int i = 0; i < 5; i++) pz[i] = 0;
                if (it == 2) pz[1] = 1;
            end
            sticky = 0;
            for (int i = 0; i < n; i++) begin sticky |= pz[i]; stk[i] = sticky; end
            any_pz  = sticky;
            tgt_eff = en ? tgt : 0;
            rise    = (n > tgt_eff + 1) ? n : tgt_eff + 1;
            exp_ovr = en && (n - 1 > tgt);
            m_axis_tready = 1'b1; in_valid = 1'b0;
            repeat (3) @(negedge clk);
            ct_enable = en; const_time_cycles = CTW'(tgt);
            for (int j = 0; j <= rise + 2; j++) begin
                p = j - 1;
                if (p >= 0) begin
                    exp_v = 0; bi = 0;
                    if (p >= 1 && p <= n - 1) begin exp_v = 1; bi = p - 1; end
                    else if (p == rise) begin exp_v = 1; bi = n - 1; end
                    checks++; if (m_axis_tvalid !== exp_v) begin errors++;
                        $display("FAIL frame_tvalid it=%0d p=%0d got=%b exp=%b", it, p,
                                 m_axis_tvalid, exp_v); end
                    if (exp_v) begin
                        exp_user = {stk[bi], u[bi]};
                        checks++; if (m_axis_tdata !== d[bi]) begin errors++;
                            $display("FAIL frame_tdata it=%0d p=%0d got=%h exp=%h", it, p,
                                     m_axis_tdata, d[bi]); end
                        checks++; if (m_axis_tuser !== exp_user) begin errors++;
                            $display("FAIL frame_tuser it=%0d p=%0d got=%h exp=%h", it, p,
                                     m_axis_tuser, exp_user); end
                        checks++; if (m_axis_tlast !== (bi == n - 1)) begin errors++;
                            $display("FAIL frame_tlast it=%0d p=%0d got=%b exp=%b", it, p,
                                     m_axis_tlast, (bi == n - 1)); end
                    end
                    checks++; if (in_ready !== 1'b1) begin errors++;
                        $display("FAIL frame_in_ready it=%0d p=%0d got=%b exp=1", it, p, in_ready); end
                    checks++;
                    if ({frame_sent, poison_seen, ct_overrun} !==
                        {p == rise + 1, (p == rise + 1) && any_pz, (p == rise + 1) && exp_ovr})
                    begin errors++;
                        $display("FAIL frame_pulses it=%0d p=%0d got=%b exp=%b", it, p,
                                 {frame_sent, poison_seen, ct_overrun},
                                 {p == rise + 1, (p == rise + 1) && any_pz,
                                  (p == rise + 1) && exp_ovr}); end
                end
                if (j < n) begin
                    in_valid = 1'b1; in_data = d[j]; in_tuser = {1'($urandom), u[j]};
                    in_last = (j == n - 1); in_poison = pz[j];
                end else begin
                    in_valid = 1'b0; in_last = 1'b0; in_poison = 1'b0;
                end
                // Settings changed after frame start must not affect this frame.
                if (j == 2) begin
                    ct_enable = 1'($urandom); const_time_cycles = CTW'($urandom);
                end
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] d [4];
        bit exp_v [7];
        int idx [7];
        d[0] = $urandom; d[1] = $urandom; d[2] = $urandom; d[3] = $urandom;
        exp_v = '{0, 1, 1, 0, 1, 1, 0};
        idx   = '{0, 0, 1, 0, 2, 3, 0};
        ct_enable = 1'b0; m_axis_tready = 1'b1;
        repeat (3) @(negedge clk);
        for (int j = 0; j <= 7; j++) begin
            if (j >= 1) begin
                checks++; if (m_axis_tvalid !== exp_v[j-1]) begin errors++;
                    $display("FAIL b2b_tvalid p=%0d got=%b exp=%b", j - 1, m_axis_tvalid,
                             exp_v[j-1]); end
                if (exp_v[j-1]) begin
                    checks++; if (m_axis_tdata !== d[idx[j-1]]) begin errors++;
                        $display("FAIL b2b_tdata p=%0d got=%h exp=%h", j - 1, m_axis_tdata,
                                 d[idx[j-1]]); end
                end
                checks++; if (frame_sent !== (j - 1 == 3 || j - 1 == 6)) begin errors++;
                    $display("FAIL b2b_frame_sent p=%0d got=%b", j - 1, frame_sent); end
            end
            if (j < 4) begin
                in_valid = 1'b1; in_data = d[j]; in_tuser = '0; in_poison = 1'b0;
                in_last = (j == 1 || j == 3);
            end else begin
                in_valid = 1'b0; in_last = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        int got;
        m_axis_tready = 1'b0; ct_enable = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            checks++; if (in_ready !== (i < D)) begin errors++;
                $display("FAIL bp_in_ready i=%0d got=%b exp=%b", i, in_ready, (i < D)); end
            in_valid = 1'b1; in_data = 32'hA0 + i; in_tuser = 8'(i); in_last = (i == 3);
            in_poison = 1'b0;
            @(negedge clk);
            checks++; if (fifo_level !== 3'((i + 1 < D) ? i + 1 : D)) begin errors++;
                $display("FAIL bp_level i=%0d got=%0d exp=%0d", i, fifo_level,
                         (i + 1 < D) ? i + 1 : D); end
            if (i >= 1) begin
                checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'hA0) begin errors++;
                    $display("FAIL bp_stable i=%0d got=%b/%h exp=1/a0", i, m_axis_tvalid,
                             m_axis_tdata); end
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        m_axis_tready = 1'b1;
        got = 0;
        for (int k = 0; k < 10; k++) begin
            if (m_axis_tvalid) begin
                checks++;
                if (got >= D || m_axis_tdata !== 32'(32'hA0 + got)) begin errors++;
                    $display("FAIL bp_drain beat=%0d got=%h exp=%h", got, m_axis_tdata,
                             32'hA0 + got); end
                got++;
            end
            @(negedge clk);
        end
        checks++; if (got !== D) begin errors++;
            $display("FAIL bp_drain_count got=%0d exp=%0d", got, D); end
        checks++; if (fifo_level !== 3'd0) begin errors++;
            $display("FAIL bp_drain_level got=%0d exp=0", fifo_level); end
    endtask

    task automatic test_reset_in_hold();
        ct_enable = 1'b1; const_time_cycles = 14'd60; m_axis_tready = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 32'hC0 + i; in_tuser = '0; in_poison = 1'b0;
            in_last = (i == 0);
            @(negedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (m_axis_tvalid !== 1'b0 || fifo_level !== 3'd3) begin errors++;
            $display("FAIL hold_state got=%b/%0d exp=0/3", m_axis_tvalid, fifo_level); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (m_axis_tvalid !== 1'b0 || fifo_level !== 3'd0 || in_ready !== 1'b1)
        begin errors++;
            $display("FAIL hold_async_reset got=%b/%0d/%b exp=0/0/1", m_axis_tvalid,
                     fifo_level, in_ready); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++; if (m_axis_tvalid !== 1'b0 || fifo_level !== 3'd0) begin errors++;
                $display("FAIL hold_post_reset k=%0d got=%b/%0d exp=0/0", k, m_axis_tvalid,
                         fifo_level); end
        end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_back_to_back();
        test_backpressure();
        test_reset_in_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
